gobang_board_server: RTL and testbench

Board-state responder for the Gobang datapath. It holds the 15×15 two-colour board and accepts stone placements through a valid/ready handshake. Each cycle it answers the (`get_i`, `get_j`) probe issued by `gobang_strategy` with the eight 9-cell line windows (`black_*`, `white_*`) that the strategy consumes. It sits between the move controller (PS/AXI side) and `gobang_strategy`.

---
 rtl/gobang_pkg.sv | 29 ++
 rtl/gobang_line_window.sv | 27 ++
 rtl/gobang_board_server.sv | 135 +++++++++++++
 tb/tb_gobang_board_server.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// Shared constants, types and the off-board cell lookup for the Gobang board server.
package gobang_pkg;

    localparam int unsigned BOARD_N  = 15;
    localparam int unsigned CW       = 4;
    localparam int unsigned WIN_W    = 9;
    localparam int unsigned WIN_HALF = 4;
    localparam int unsigned CNT_W    = 8;

    localparam logic C_BLACK = 1'b0;
    localparam logic C_WHITE = 1'b1;

    typedef logic [CW-1:0]                   coord_t;
    typedef logic [BOARD_N-1:0][BOARD_N-1:0] plane_t;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    // Cells outside the board read as the edge fill value.
    function automatic logic cell_at(input plane_t p, input int r, input int c, input logic fill);
        if (r < 0 || c < 0 || r >= int'(BOARD_N) || c >= int'(BOARD_N)) begin
            return fill;
        end
        return p[CW'(r)][CW'(c)];
    endfunction

endpackage

// File: rtl/gobang_line_window.sv
// Combinational 9-cell line window around a centre along step (DI, DJ), with edge fill.
module gobang_line_window
    import gobang_pkg::*;
#(
    parameter int   DI        = 0,
    parameter int   DJ        = 1,
    parameter logic EDGE_FILL = 1'b0
) (
    input  plane_t           plane_i,
    input  coord_t           ci_i,
    input  coord_t           cj_i,
    output logic [WIN_W-1:0] win_o
);

    always_comb begin
        win_o = {WIN_W{EDGE_FILL}};
        if (ci_i < CW'(BOARD_N) && cj_i < CW'(BOARD_N)) begin
            for (int k = 0; k < int'(WIN_W); k++) begin
                win_o[k] = cell_at(plane_i,
                                   int'(ci_i) + (k - int'(WIN_HALF)) * DI,
                                   int'(cj_i) + (k - int'(WIN_HALF)) * DJ,
                                   EDGE_FILL);
            end
        end
    end

endmodule

// File: rtl/gobang_board_server.sv
// 15x15 two-colour board with placement handshake, row-by-row clear and registered line windows.
// Optional: define GOBANG_EDGE_BLOCKED_EN to make off-board cells read as blocking stones.
module gobang_board_server
    import gobang_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [CW-1:0]    move_i,
    input  logic [CW-1:0]    move_j,
    input  logic             move_color,
    output logic             move_err,
    output logic [CNT_W-1:0] stone_cnt,
    output logic             board_full,
    input  logic [CW-1:0]    get_i,
    input  logic [CW-1:0]    get_j,
    output logic [WIN_W-1:0] black_i,
    output logic [WIN_W-1:0] black_j,
    output logic [WIN_W-1:0] black_ij,
    output logic [WIN_W-1:0] black_ji,
    output logic [WIN_W-1:0] white_i,
    output logic [WIN_W-1:0] white_j,
    output logic [WIN_W-1:0] white_ij,
    output logic [WIN_W-1:0] white_ji,
    output logic             line_valid
);

`ifdef GOBANG_EDGE_BLOCKED_EN
    localparam logic EDGE_FILL = 1'b1;
`else
    localparam logic EDGE_FILL = 1'b0;
`endif

    state_e            state_q, state_d;
    coord_t            row_q, row_d;
    plane_t            blk_q, blk_d, wht_q, wht_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, err_q, err_d, ready_q, lv_q;
    logic [7:0][WIN_W-1:0] win_q, win_c;

    // Windows 0..3 are black row/col/diag/anti-diag, 4..7 the same for white.
    for (genvar g = 0; g < 8; g++) begin : g_win
        localparam int D = g % 4;
        gobang_line_window #(
            .DI        ((D == 0) ? 0 : 1),
            .DJ        ((D == 1) ? 0 : ((D == 3) ? -1 : 1)),
            .EDGE_FILL (EDGE_FILL)
        ) u_win (
            .plane_i (g < 4 ? blk_q : wht_q),
            .ci_i    (get_i),
            .cj_i    (get_j),
            .win_o   (win_c[g])
        );
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        blk_d   = blk_q;
        wht_d   = wht_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    row_d   = '0;
                end else if (move_valid) begin
                    if (move_i < CW'(BOARD_N) && move_j < CW'(BOARD_N) && !full_q
                        && !blk_q[move_i][move_j] && !wht_q[move_i][move_j]) begin
                        if (move_color == C_BLACK) blk_d[move_i][move_j] = 1'b1;
                        else                       wht_d[move_i][move_j] = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                blk_d[row_q] = '0;
                wht_d[row_q] = '0;
                if (row_q == CW'(BOARD_N - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            blk_q   <= '0;
            wht_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            lv_q    <= 1'b1;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            wht_q   <= wht_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(BOARD_N * BOARD_N));
            err_q   <= err_d;
            ready_q <= (state_d == S_IDLE);
            // Stays low one extra cycle so the last cleared row is reflected in the windows.
            lv_q    <= (state_d == S_IDLE) && (state_q == S_IDLE);
            win_q   <= win_c;
        end
    end

    assign move_ready = ready_q;
    assign move_err   = err_q;
    assign stone_cnt  = cnt_q;
    assign board_full = full_q;
    assign line_valid = lv_q;
    assign black_i    = win_q[0];
    assign black_j    = win_q[1];
    assign black_ij   = win_q[2];
    assign black_ji   = win_q[3];
    assign white_i    = win_q[4];
    assign white_j    = win_q[5];
    assign white_ij   = win_q[6];
    assign white_ji   = win_q[7];

endmodule

// File: tb/tb_gobang_board_server.sv
// Self-checking bench for gobang_board_server: vector table, hand sequences and random moves vs a board model.
module tb_gobang_board_server;

`ifdef GOBANG_EDGE_BLOCKED_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, move_valid = 1'b0, move_color = 1'b0;
    logic [3:0] move_i = '0, move_j = '0, get_i = '0, get_j = '0;
    logic move_ready, move_err, board_full, line_valid;
    logic [7:0] stone_cnt;
    logic [8:0] black_i, black_j, black_ij, black_ji, white_i, white_j, white_ij, white_ji;

    gobang_board_server dut (
        .clk(clk), .rst(rst), .clr(clr), .move_valid(move_valid), .move_ready(move_ready),
        .move_i(move_i), .move_j(move_j), .move_color(move_color), .move_err(move_err),
        .stone_cnt(stone_cnt), .board_full(board_full), .get_i(get_i), .get_j(get_j),
        .black_i(black_i), .black_j(black_j), .black_ij(black_ij), .black_ji(black_ji),
        .white_i(white_i), .white_j(white_j), .white_ij(white_ij), .white_ji(white_ji),
        .line_valid(line_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit mb [15][15];
    bit mw [15][15];
    int mcnt = 0;

    typedef struct {
        bit mv; int mi; int mj; bit mc; int pi; int pj; bit exp_err; int exp_cnt;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mwin(input bit white, input int i, input int j, input int dir);
        int di, dj, r, c;
        logic [8:0] w;
        di = (dir == 0) ? 0 : 1;
        dj = (dir == 1) ? 0 : ((dir == 3) ? -1 : 1);
        for (int k = 0; k < 9; k++) begin
            r = i + (k - 4) * di;
            c = j + (k - 4) * dj;
            if (i >= 15 || j >= 15 || r < 0 || r > 14 || c < 0 || c > 14) w[k] = FILL;
            else w[k] = white ? mw[r][c] : mb[r][c];
        end
        return w;
    endfunction

    function automatic logic [8:0] act_win(input int g);
        case (g)
            0: return black_i;  1: return black_j;  2: return black_ij; 3: return black_ji;
            4: return white_i;  5: return white_j;  6: return white_ij; default: return white_ji;
        endcase
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) begin
                mb[r][c] = 1'b0;
                mw[r][c] = 1'b0;
            end
        mcnt = 0;
    endfunction

    // One IDLE cycle: optional move plus a probe, checked against the model's pre-edge board.
    task automatic step(input bit mv, input int mi, input int mj, input bit mc,
                        input int pi, input int pj, input string tag);
        logic [8:0] ew [8];
        bit eerr;
        for (int g = 0; g < 8; g++) ew[g] = mwin(g >= 4, pi, pj, g % 4);
        eerr = 1'b0;
        if (mv) begin
            if (mi >= 15 || mj >= 15) eerr = 1'b1;
            else if (mb[mi][mj] || mw[mi][mj]) eerr = 1'b1;
        end
        move_valid = mv; move_i = 4'(mi); move_j = 4'(mj); move_color = mc;
        get_i = 4'(pi); get_j = 4'(pj);
        tick();
        move_valid = 1'b0;
        if (mv && !eerr) begin
            if (mc) mw[mi][mj] = 1'b1;
            else    mb[mi][mj] = 1'b1;
            mcnt++;
        end
        chk({tag, " err"}, 32'(move_err), 32'(eerr));
        chk({tag, " cnt"}, 32'(stone_cnt), 32'(mcnt));
        chk({tag, " full"}, 32'(board_full), 32'(mcnt == 225));
        chk({tag, " lv"}, 32'(line_valid), 32'd1);
        for (int g = 0; g < 8; g++)
            chk($sformatf("%s win%0d", tag, g), 32'(act_win(g)), 32'(ew[g]));
    endtask

    initial begin
        int rl, ll, prev;
        vecs[0] = '{1, 7, 7, 0, 7, 7, 0, 1};
        vecs[1] = '{1, 7, 8, 1, 7, 7, 0, 2};
        vecs[2] = '{1, 9, 9, 0, 0, 0, 0, 3};
        vecs[3] = '{1, 7, 7, 1, 7, 7, 1, 3};
        vecs[4] = '{0, 0, 0, 0, 7, 7, 0, 3};
        vecs[5] = '{1, 15, 0, 0, 3, 3, 1, 3};
        vecs[6] = '{1, 0, 15, 1, 3, 3, 1, 3};
        vecs[7] = '{1, 14, 14, 1, 14, 14, 0, 4};

        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst cnt", 32'(stone_cnt), 32'd0);
        chk("rst ready", 32'(move_ready), 32'd1);
        chk("rst lv", 32'(line_valid), 32'd1);
        chk("rst full", 32'(board_full), 32'd0);
        chk("rst err", 32'(move_err), 32'd0);
        for (int g = 0; g < 8; g++) chk($sformatf("rst win%0d", g), 32'(act_win(g)), 32'd0);

        // Corner probe on an empty board.
        step(0, 0, 0, 0, 0, 0, "corner");
        chk("corner bij", 32'(black_ij), FILL ? 32'h00f : 32'h000);
        chk("corner wij", 32'(white_ij), FILL ? 32'h00f : 32'h000);

        for (int v = 0; v < 8; v++) begin
            step(vecs[v].mv, vecs[v].mi, vecs[v].mj, vecs[v].mc, vecs[v].pi, vecs[v].pj,
                 $sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl err", v), 32'(move_err), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d tbl cnt", v), 32'(stone_cnt), 32'(vecs[v].exp_cnt));
        end
        step(0, 0, 0, 0, 7, 7, "p77");
        chk("p77 black_i", 32'(black_i), 32'h010);
        chk("p77 white_i", 32'(white_i), 32'h020);
        chk("p77 black_ij", 32'(black_ij), 32'h050);

        // Read-before-write: probe shows the old cell, the next probe the new stone.
        step(1, 3, 3, 0, 3, 3, "rbw0");
        chk("rbw old", 32'(black_i[4]), 32'd0);
        step(0, 0, 0, 0, 3, 3, "rbw1");
        chk("rbw new", 32'(black_i[4]), 32'd1);

        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 $sformatf("rnd%0d", n));

        // clr with a simultaneous move: clr wins, held clr does not restart the clear.
        prev = mcnt;
        clr = 1'b1; move_valid = 1'b1; move_i = 4'd5; move_j = 4'd6; move_color = 1'b0;
        tick();
        move_valid = 1'b0;
        chk("clr ready", 32'(move_ready), 32'd0);
        chk("clr lv", 32'(line_valid), 32'd0);
        chk("clr err", 32'(move_err), 32'd0);
        chk("clr cnt", 32'(stone_cnt), 32'(prev));
        rl = 1; ll = 1;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) clr = 1'b0;
            if (move_ready && line_valid) break;
            tick();
            if (!move_ready) rl++;
            if (!line_valid) ll++;
        end
        chk("clr ready_low_cycles", 32'(rl), 32'd15);
        chk("clr lv_low_cycles", 32'(ll), 32'd16);
        model_clear();
        chk("clr cnt0", 32'(stone_cnt), 32'd0);
        step(0, 0, 0, 0, 7, 7, "post_clr77");
        step(0, 0, 0, 0, 5, 6, "post_clr56");

        // Reset in the middle of a clear aborts it.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        chk("midclr ready", 32'(move_ready), 32'd0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rstclr ready", 32'(move_ready), 32'd1);
        chk("rstclr lv", 32'(line_valid), 32'd1);
        chk("rstclr cnt", 32'(stone_cnt), 32'd0);
        chk("rstclr win", 32'(black_i), 32'd0);
        step(1, 2, 2, 1, 2, 2, "rstclr move");

        // Fill the rest of the board, alternating colours.
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                if (!(r == 2 && c == 2)) step(1, r, c, 1'((r * 15 + c) % 2), r, c, $sformatf("fill%0d_%0d", r, c));
        chk("full cnt", 32'(stone_cnt), 32'd225);
        chk("full flag", 32'(board_full), 32'd1);
        step(1, 0, 0, 0, 7, 7, "full move");
        chk("full move err", 32'(move_err), 32'd1);
        step(0, 0, 0, 0, 0, 14, "full idle");
        chk("full err clr", 32'(move_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
